// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor: the lamp encoding,
// the fault cause codes and the monitor state type.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  // Fault causes. A lower value wins when several are seen on the same edge.
  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_ENC      = 3'd1;
  localparam logic [2:0] FLT_CONFLICT = 3'd2;
  localparam logic [2:0] FLT_TRANS    = 3'd3;
  localparam logic [2:0] FLT_SHORT_Y  = 3'd4;

  typedef enum logic {
    MONITOR = 1'b0,
    FAULT   = 1'b1
  } state_t;

  // True for the three one-hot lamp values; everything else is illegal.
  function automatic logic is_legal(input logic [2:0] light);
    return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/lane_checker.sv
// Per-lane checker: remembers the previous lamp sample and the length of the
// current yellow run, and flags encoding, transition and short-yellow errors
// for the sample presented this cycle.
module lane_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       update,
  input  logic       clear,
  output logic       enc_err,
  output logic       trans_err,
  output logic       short_y_err
);

  localparam int CW = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
  localparam logic [CW-1:0] Y_MAX = CW'(MIN_YELLOW);

  logic [2:0]    prev;
  logic [CW-1:0] y_cnt;

  // Error flags are purely a function of the current sample and lane history.
  always_comb begin
    enc_err     = !is_legal(light);
    trans_err   = is_legal(light) && is_legal(prev) &&
                  (((prev == LIGHT_GREEN)  && (light == LIGHT_RED))    ||
                   ((prev == LIGHT_RED)    && (light == LIGHT_YELLOW)) ||
                   ((prev == LIGHT_YELLOW) && (light == LIGHT_GREEN)));
    short_y_err = (prev == LIGHT_YELLOW) && (light == LIGHT_RED) && (y_cnt < Y_MAX);
  end

  // Lane history: reset/clear to red with no yellow run, otherwise follow the
  // input on every monitored cycle (fault-detection cycles included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= LIGHT_RED;
      y_cnt <= '0;
    end else if (clear) begin
      prev  <= LIGHT_RED;
      y_cnt <= '0;
    end else if (update) begin
      prev <= light;
      if (light == LIGHT_YELLOW) begin
        if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
      end else begin
        y_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor between a traffic light controller and the lamps. Legal
// light patterns pass through with one cycle of latency; the first illegal
// pattern latches a fault and the lamps flash yellow until fault_clr.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       fault_clr,
  output logic [2:0] safe_M1,
  output logic [2:0] safe_M2,
  output logic [2:0] safe_MT,
  output logic [2:0] safe_S,
  output logic       fault,
  output logic [2:0] fault_code,
  output state_t     state
);

  localparam int FW = (2 * FLASH_HALF < 2) ? 1 : $clog2(2 * FLASH_HALF);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_ON   = FW'(FLASH_HALF);

  // Lane order: 0 = M1, 1 = M2, 2 = MT, 3 = S.
  logic [2:0] lights [4];
  logic [3:0] enc_err;
  logic [3:0] trans_err;
  logic [3:0] short_y_err;
  logic       conflict;
  logic [2:0] detect_code;
  logic       lane_update;
  logic       lane_clear;
  logic [FW-1:0] flash_cnt;
  logic [FW-1:0] flash_next;

  assign lights[0] = light_M1;
  assign lights[1] = light_M2;
  assign lights[2] = light_MT;
  assign lights[3] = light_S;

  assign lane_update = (state == MONITOR);
  assign lane_clear  = (state == FAULT) && fault_clr;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_checker #(
      .MIN_YELLOW(MIN_YELLOW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .light      (lights[i]),
      .update     (lane_update),
      .clear      (lane_clear),
      .enc_err    (enc_err[i]),
      .trans_err  (trans_err[i]),
      .short_y_err(short_y_err[i])
    );
  end

  // Cross-lane conflicts: side street against any main movement, and the
  // main through lane M2 against the turn lane MT.
  always_comb begin
    conflict = ((light_S != LIGHT_RED) &&
                ((light_M1 != LIGHT_RED) || (light_M2 != LIGHT_RED) || (light_MT != LIGHT_RED))) ||
               ((light_M2 != LIGHT_RED) && (light_MT != LIGHT_RED));
  end

  // Priority resolution: later assignments override, so the lowest code wins.
  always_comb begin
    detect_code = FLT_NONE;
    if (|short_y_err) detect_code = FLT_SHORT_Y;
    if (|trans_err)   detect_code = FLT_TRANS;
    if (conflict)     detect_code = FLT_CONFLICT;
    if (|enc_err)     detect_code = FLT_ENC;
  end

  // Flash counter successor, wrapping after one full on/off period.
  always_comb begin
    flash_next = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;
  end

  // Monitor FSM with registered lamp drive, fault flag, cause and flash count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MONITOR;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      flash_cnt  <= '0;
      safe_M1    <= LIGHT_RED;
      safe_M2    <= LIGHT_RED;
      safe_MT    <= LIGHT_RED;
      safe_S     <= LIGHT_RED;
    end else begin
      case (state)
        MONITOR: begin
          if (detect_code != FLT_NONE) begin
            // The offending sample is dropped; flashing starts lit.
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= detect_code;
            flash_cnt  <= '0;
            safe_M1    <= LIGHT_YELLOW;
            safe_M2    <= LIGHT_YELLOW;
            safe_MT    <= LIGHT_YELLOW;
            safe_S     <= LIGHT_YELLOW;
          end else begin
            safe_M1 <= light_M1;
            safe_M2 <= light_M2;
            safe_MT <= light_MT;
            safe_S  <= light_S;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state      <= MONITOR;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            flash_cnt  <= '0;
            safe_M1    <= LIGHT_RED;
            safe_M2    <= LIGHT_RED;
            safe_MT    <= LIGHT_RED;
            safe_S     <= LIGHT_RED;
          end else begin
            flash_cnt <= flash_next;
            safe_M1   <= (flash_next < FLASH_ON) ? LIGHT_YELLOW : LIGHT_OFF;
            safe_M2   <= (flash_next < FLASH_ON) ? LIGHT_YELLOW : LIGHT_OFF;
            safe_MT   <= (flash_next < FLASH_ON) ? LIGHT_YELLOW : LIGHT_OFF;
            safe_S    <= (flash_next < FLASH_ON) ? LIGHT_YELLOW : LIGHT_OFF;
          end
        end
        default: begin
          state <= MONITOR;
        end
      endcase
    end
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3: minimum consecutive yellow cycles per lane before red is legal.
REQ-002 Parameter FLASH_HALF, default 5: cycles per half-period of fault flashing.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 light_M1, light_M2, light_MT, light_S  input  3 each  light buses from the upstream traffic_light_controller.
REQ-006 Light encoding: red 3'b100, yellow 3'b010, green 3'b001; every other value is illegal.
REQ-007 fault_clr  input  1  request to leave the fault state; ignored outside FAULT.
REQ-008 safe_M1, safe_M2, safe_MT, safe_S  output  3 each  registered lamp drive.
REQ-009 fault  output  1  sticky fault flag.
REQ-010 fault_code  output  3  cause of the first latched fault; 0 when no fault.

Function
REQ-011 The FSM SHALL have exactly two states, MONITOR and FAULT.
REQ-012 In MONITOR with no fault detected, each safe_X SHALL equal light_X sampled on the same edge (1-cycle latency).
REQ-013 Per-lane encoding check: any illegal value -> code 1.
REQ-014 Conflict check: S non-red while any of M1/M2/MT is non-red, or M2 non-red while MT is non-red -> code 2.
REQ-015 Transition check against the previous sample: legal moves are red->green, green->yellow, yellow->red, or no change. green->red, red->yellow and yellow->green -> code 3.
REQ-016 Per-lane yellow counter: counts consecutive yellow samples, saturating at MIN_YELLOW, and clears on any non-yellow sample.
REQ-017 A yellow->red move with counter < MIN_YELLOW -> code 4.
REQ-018 Simultaneous faults, within one lane or across lanes: the lowest code SHALL be latched.
REQ-019 On the edge a fault is detected: state->FAULT, fault=1, fault_code latched, and the offending inputs SHALL never reach safe_X.
REQ-020 In FAULT, the flash counter SHALL start at 0 on fault entry.
REQ-021 In FAULT, all safe_X = yellow for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating; the counter wraps at 2*FLASH_HALF-1.
REQ-022 In FAULT, further faults SHALL NOT alter fault_code, and inputs SHALL be ignored.
REQ-023 fault_clr=1 in FAULT: on the next edge state->MONITOR, fault=0, fault_code=0, all safe_X=red, previous samples reset to red, yellow counters cleared.
REQ-024 Checks SHALL resume on the edge after a clear.
REQ-025 The previous-sample registers SHALL update every MONITOR cycle, including fault-detection cycles.

Reset
REQ-026 rst low SHALL immediately force state MONITOR, fault=0, fault_code=0, all safe_X=red, all previous samples=red, yellow and flash counters=0.
REQ-027 Reset asserted mid-flash or mid-yellow SHALL abandon that activity with no residual state.
REQ-028 After reset, a first sample of green is legal, because the previous sample is red.

Structure
REQ-029 Shared package traffic_pkg SHALL hold: the light encoding constants; fault codes FLT_NONE=0, FLT_ENC=1, FLT_CONFLICT=2, FLT_TRANS=3, FLT_SHORT_Y=4; and the state enum.
REQ-030 Sub-module lane_checker SHALL contain the previous-sample register, the yellow counter, and the encoding/transition/short-yellow flags, instantiated four times.
REQ-031 Conflict detection, priority resolution, FSM and flash counter SHALL live in the top.

Verification
REQ-032 Legal sequence M1 red->green->yellow x3->red, all others red -> safe_M1 tracks with 1-cycle delay; fault stays 0.
REQ-033 light_S=3'b011 for one cycle -> fault=1 and fault_code=1 next edge; safe_* = 3'b010 for 5 cycles, then 3'b000 for 5 cycles.
REQ-034 light_S=green while light_M1=green -> fault_code=2; the green/green pair never appears on safe_*.
REQ-035 light_MT yellow for 2 cycles then red -> fault_code=4; in the same cycle, illegal M2 3'b111 -> fault_code=1 (priority).
REQ-036 Assert fault_clr in FAULT -> next edge fault=0, safe_*=3'b100; a subsequent legal red->green passes without fault.
REQ-037 Pull rst low mid-flash -> outputs red and fault=0 asynchronously, before the next clk edge.
